// File: rtl/i2c_codec_target.sv
// Write-only I2C target for the audio codec control port: 7-bit address, {reg[6:0], data[8:0]} frames.
// SCL/SDA are oversampled on clk; accepted frames update a bank of 9-bit shadow registers.
module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2,
   parameter int         NUM_REGS    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_sclk,
   input  logic       i2c_sdat_i,
   output logic       i2c_sdat_oe,
   output logic       reg_wr_en,
   output logic [6:0] reg_addr,
   output logic [8:0] reg_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       bus_busy
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ADDR      = 3'd1,
      S_ACK_A     = 3'd2,
      S_BYTE1     = 3'd3,
      S_ACK_1     = 3'd4,
      S_BYTE2     = 3'd5,
      S_ACK_2     = 3'd6,
      S_WAIT_STOP = 3'd7
   } state_t;

   localparam logic [6:0] SOFT_RST_ADDR = 7'h0F;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_hist;
   logic                   r_sda_hist;
   logic                   w_scl;
   logic                   w_sda;
   logic                   w_scl_rise;
   logic                   w_scl_fall;
   logic                   w_start;
   logic                   w_stop;
   logic                   w_in_byte;

   state_t     r_state,     w_state_nxt;
   logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
   logic       r_byte_full, w_byte_full_nxt;
   logic [7:0] r_shift,     w_shift_nxt;
   logic [7:0] r_byte1,     w_byte1_nxt;
   logic       r_oe,        w_oe_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_wr_en,     w_wr_en_nxt;
   logic [6:0] r_reg_addr,  w_reg_addr_nxt;
   logic [8:0] r_reg_data,  w_reg_data_nxt;
   logic [8:0] r_shadow [NUM_REGS];
   logic [8:0] w_rd_data;

   // Pin synchronizers plus one history flop; idle bus level is high, so reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_hist <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_sclk};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sdat_i};
         r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
         r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_hist;
   assign w_scl_fall = ~w_scl & r_scl_hist;
   assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
   assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
   assign w_in_byte  = (r_state == S_ADDR) || (r_state == S_BYTE1) || (r_state == S_BYTE2);

   // Next-state and next-output logic; bus conditions override any byte/ACK progress.
   always_comb begin
      w_state_nxt     = r_state;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_byte_full_nxt = r_byte_full;
      w_shift_nxt     = r_shift;
      w_byte1_nxt     = r_byte1;
      w_oe_nxt        = r_oe;
      w_busy_nxt      = r_busy;
      w_wr_en_nxt     = 1'b0;
      w_reg_addr_nxt  = r_reg_addr;
      w_reg_data_nxt  = r_reg_data;
      if (w_stop) begin
         w_state_nxt     = S_IDLE;
         w_oe_nxt        = 1'b0;
         w_busy_nxt      = 1'b0;
         w_bit_cnt_nxt   = 3'd0;
         w_byte_full_nxt = 1'b0;
      end else if (w_start) begin
         w_state_nxt     = S_ADDR;
         w_oe_nxt        = 1'b0;
         w_busy_nxt      = 1'b1;
         w_bit_cnt_nxt   = 3'd0;
         w_byte_full_nxt = 1'b0;
      end else if (w_scl_rise && w_in_byte) begin
         w_shift_nxt   = {r_shift[6:0], w_sda};
         w_bit_cnt_nxt = r_bit_cnt + 3'd1;
         if (r_bit_cnt == 3'd7) begin
            w_byte_full_nxt = 1'b1;
         end else begin
            w_byte_full_nxt = r_byte_full;
         end
      end else if (w_scl_fall) begin
         // A full byte is acted on at the falling edge that ends its eighth bit.
         case (r_state)
            S_ADDR: begin
               if (r_byte_full) begin
                  w_byte_full_nxt = 1'b0;
                  if ((r_shift[7:1] == DEV_ADDR) && (r_shift[0] == 1'b0)) begin
                     w_state_nxt = S_ACK_A;
                     w_oe_nxt    = 1'b1;
                  end else begin
                     w_state_nxt = S_WAIT_STOP;
                  end
               end else begin
                  w_state_nxt = r_state;
               end
            end
            S_BYTE1: begin
               if (r_byte_full) begin
                  w_byte_full_nxt = 1'b0;
                  w_byte1_nxt     = r_shift;
                  w_state_nxt     = S_ACK_1;
                  w_oe_nxt        = 1'b1;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            S_BYTE2: begin
               if (r_byte_full) begin
                  w_byte_full_nxt = 1'b0;
                  w_state_nxt     = S_ACK_2;
                  w_oe_nxt        = 1'b1;
                  w_wr_en_nxt     = 1'b1;
                  w_reg_addr_nxt  = r_byte1[7:1];
                  w_reg_data_nxt  = {r_byte1[0], r_shift};
               end else begin
                  w_state_nxt = r_state;
               end
            end
            S_ACK_A: begin
               w_oe_nxt    = 1'b0;
               w_state_nxt = S_BYTE1;
            end
            S_ACK_1: begin
               w_oe_nxt    = 1'b0;
               w_state_nxt = S_BYTE2;
            end
            S_ACK_2: begin
               w_oe_nxt    = 1'b0;
               w_state_nxt = S_WAIT_STOP;
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= 3'd0;
         r_byte_full <= 1'b0;
         r_shift     <= 8'd0;
         r_byte1     <= 8'd0;
         r_oe        <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_reg_addr  <= 7'd0;
         r_reg_data  <= 9'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_byte_full <= w_byte_full_nxt;
         r_shift     <= w_shift_nxt;
         r_byte1     <= w_byte1_nxt;
         r_oe        <= w_oe_nxt;
         r_busy      <= w_busy_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_reg_addr  <= w_reg_addr_nxt;
         r_reg_data  <= w_reg_data_nxt;
      end
   end

   // Shadow bank updates in the same clk as the write pulse; address 0x0F clears the bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= 9'd0;
      end else if (w_wr_en_nxt) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_reg_addr_nxt == i[6:0]) begin
               r_shadow[i] <= w_reg_data_nxt;
            end else if (w_reg_addr_nxt == SOFT_RST_ADDR) begin
               r_shadow[i] <= 9'd0;
            end else begin
               r_shadow[i] <= r_shadow[i];
            end
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= r_shadow[i];
      end
   end

   // Read mux; indices beyond the bank read as zero.
   always_comb begin
      w_rd_data = 9'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_rd_data = w_rd_data | (r_shadow[i] & {9{rd_addr == i[3:0]}});
      end
   end

   assign i2c_sdat_oe = r_oe;
   assign reg_wr_en   = r_wr_en;
   assign reg_addr    = r_reg_addr;
   assign reg_data    = r_reg_data;
   assign bus_busy    = r_busy;
   assign rd_data     = w_rd_data;
endmodule

// File: tb/tb_i2c_codec_target.sv
// Bit-banged I2C master driving i2c_codec_target; a scoreboard queue checks write pulses
// and a shadow-register model checks ACKs and read-back values.
module tb_i2c_codec_target;
   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic       sda_bus;
   logic       oe;
   logic       wr_en;
   logic [6:0] reg_addr;
   logic [8:0] reg_data;
   logic [3:0] rd_addr;
   logic [8:0] rd_data;
   logic       busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e_v;
   logic [8:0]  model [16];

   always #5 clk = ~clk;
   assign sda_bus = sda_m & ~oe;

   i2c_codec_target dut (
      .clk        (clk),
      .rst        (rst),
      .i2c_sclk   (scl),
      .i2c_sdat_i (sda_bus),
      .i2c_sdat_oe(oe),
      .reg_wr_en  (wr_en),
      .reg_addr   (reg_addr),
      .reg_data   (reg_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .bus_busy   (busy)
   );

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every write pulse must match the oldest outstanding expected frame.
   always @(negedge clk) begin
      if (!rst && wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no pulse", reg_addr, reg_data);
         end else begin
            e_v = exp_q.pop_front();
            check("wr_pulse", {reg_addr, reg_data}, e_v);
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model[i] = 9'd0;
   endtask

   task automatic model_write(input logic [6:0] a, input logic [8:0] d);
      exp_q.push_back({a, d});
      if (a < 7'd10) model[a[3:0]] = d;
      else if (a == 7'h0F) model_clear();
   endtask

   task automatic sweep(input string nm);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         check($sformatf("%s_r%0d", nm, a), 16'(rd_data), 16'((a < 10) ? model[a] : 9'd0));
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl   = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl   = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl   = 1'b1; wq(Q);
      sda_m = 1'b1; wq(2 * Q);
   endtask

   task automatic put_bit(input logic b);
      sda_m = b;    wq(Q);
      scl   = 1'b1; wq(2 * Q);
      scl   = 1'b0; wq(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic got;
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
      sda_m = 1'b1; wq(Q);
      scl   = 1'b1; wq(Q);
      got   = ~sda_bus; wq(Q);
      scl   = 1'b0; wq(Q);
      check(nm, 16'(got), 16'(exp_ack));
   endtask

   // One transaction: only the write byte 0x34 is ACKed, then two data bytes, nothing after.
   task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int nbytes, input bit with_stop);
      logic       addr_ok;
      logic [7:0] bv;
      i2c_start();
      check("busy_after_start", 16'(busy), 16'd1);
      addr_ok = (b0 == 8'h34);
      for (int k = 0; k < nbytes; k++) begin
         bv = (k == 0) ? b0 : (k == 1) ? b1 : (k == 2) ? b2 : b3;
         if (k == 2 && addr_ok) model_write(b1[7:1], {b1[0], b2});
         send_byte(bv, (k == 0) ? addr_ok : (addr_ok && k < 3), $sformatf("ack_b%0d", k));
      end
      if (with_stop) begin
         i2c_stop();
         check("busy_after_stop", 16'(busy), 16'd0);
      end
   endtask

   initial begin
      logic [7:0] a0;
      logic [6:0] rg;
      logic [8:0] d;
      int         nb;
      int         sel;
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
      model_clear();
      wq(3);
      check("rst_oe", 16'(oe), 16'd0);
      check("rst_wr", 16'(wr_en), 16'd0);
      check("rst_addr", 16'(reg_addr), 16'd0);
      check("rst_data", 16'(reg_data), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      sweep("rst_shadow");
      rst = 1'b0;
      wq(Q);

      // T1: basic write R4 = 0x012
      do_frame(8'h34, 8'h08, 8'h12, 8'h00, 3, 1'b1);
      check("t1_reg_addr", 16'(reg_addr), 16'h04);
      check("t1_reg_data", 16'(reg_data), 16'h012);
      rd_addr = 4'd4; #1;
      check("t1_rd4", 16'(rd_data), 16'h012);

      // T2: wrong address / read bit -> NACK, busy held until STOP
      do_frame(8'h36, 8'h0A, 8'h55, 8'h00, 3, 1'b0);
      check("t2_busy_hold", 16'(busy), 16'd1);
      i2c_stop();
      check("t2_busy_clr", 16'(busy), 16'd0);
      do_frame(8'h35, 8'h0A, 8'h55, 8'h00, 3, 1'b1);
      sweep("t2_shadow");

      // T3: truncated frame is discarded, full frame lands
      do_frame(8'h34, 8'h0A, 8'h00, 8'h00, 2, 1'b1);
      sweep("t3a_shadow");
      do_frame(8'h34, 8'h0A, 8'h04, 8'h00, 3, 1'b1);
      rd_addr = 4'd5; #1;
      check("t3_rd5", 16'(rd_data), 16'h004);

      // T4: repeated START mid byte2 discards partial frame
      i2c_start();
      send_byte(8'h34, 1'b1, "t4_ack0");
      send_byte(8'h0C, 1'b1, "t4_ack1");
      a0 = 8'hAB;
      for (int i = 7; i >= 4; i--) put_bit(a0[i]);
      do_frame(8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1);
      rd_addr = 4'd9; #1;
      check("t4_rd9", 16'(rd_data), 16'h001);
      sweep("t4_shadow");

      // T5: load shadows, then soft reset via register 0x0F; fourth byte NACKed
      do_frame(8'h34, 8'h01, 8'h55, 8'h00, 3, 1'b1);
      do_frame(8'h34, 8'h06, 8'hA5, 8'h00, 3, 1'b1);
      do_frame(8'h34, 8'h13, 8'h3C, 8'h00, 3, 1'b1);
      sweep("t5_loaded");
      do_frame(8'h34, 8'h1E, 8'h00, 8'hFF, 4, 1'b1);
      check("t5_reg_addr", 16'(reg_addr), 16'h0F);
      sweep("t5_cleared");

      // T6: async reset while ACKing byte1
      do_frame(8'h34, 8'h04, 8'h77, 8'h00, 3, 1'b1);
      i2c_start();
      send_byte(8'h34, 1'b1, "t6_ack0");
      a0 = 8'h06;
      for (int i = 7; i >= 0; i--) put_bit(a0[i]);
      sda_m = 1'b1; wq(Q);
      check("t6_oe_before_rst", 16'(oe), 16'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_oe_async", 16'(oe), 16'd0);
      model_clear();
      scl = 1'b1; wq(Q);
      check("t6_busy", 16'(busy), 16'd0);
      check("t6_addr", 16'(reg_addr), 16'd0);
      check("t6_data", 16'(reg_data), 16'd0);
      sweep("t6_rst_shadow");
      rst = 1'b0;
      wq(Q);
      do_frame(8'h34, 8'h0F, 8'hC3, 8'h00, 3, 1'b1);
      sweep("t6_after");

      // Randomized frames against the model
      for (int f = 0; f < 18; f++) begin
         sel = $urandom_range(0, 9);
         a0  = (sel < 7) ? 8'h34 : (sel == 7) ? 8'h36 : (sel == 8) ? 8'h35 : 8'($urandom_range(0, 255));
         rg  = ($urandom_range(0, 7) == 0) ? 7'h0F : 7'($urandom_range(0, 12));
         d   = 9'($urandom_range(0, 511));
         sel = $urandom_range(0, 9);
         nb  = (sel == 0) ? 2 : (sel == 1) ? 4 : 3;
         do_frame(a0, {rg, d[8]}, d[7:0], 8'($urandom_range(0, 255)), nb, 1'b1);
         sweep("rand_shadow");
      end

      wq(4);
      check("wr_queue_drained", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
